rv_fetch_unit: RTL
==================

Name: rv_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation pipelined RISC-V core.
- Replaces the single-cycle PC / PC+4 / branch-mux path with several pieces:
  - a PC register;
  - a valid/ready instruction-memory request interface;
  - a DEPTH-entry fetch queue that decouples fetch from decode;
  - a redirect port, driven by EX for taken branches and jumps, that flushes queued wrong-path instructions.
- Sits between instruction memory and the IF/ID boundary; decode consumes from its output handshake.

Parameters:
- XLEN, 64: PC and address width.
- DEPTH, 4: fetch-queue entries; power of two, ≥2.
- RESET_PC, 0: PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; reset=0 clears all state.
- imem_valid  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; equals fetch_pc.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  EX-stage redirect (taken branch or jump).
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_pc_plus4  out  XLEN  head PC + 4, modulo 2^XLEN.
- count  out  $clog2(DEPTH+1)  occupied entries.
- misalign_err  out  1  one-cycle pulse; the last redirect target had bits [1:0] ≠ 0.

Behaviour:
- Reset (reset=0 at an edge):
  - fetch_pc ← RESET_PC; queue emptied; count=0; misalign_err=0.
  - out_valid=0, and out_instr/out_pc are don't-care while invalid.
  - Reset wins over every other input, including mid-burst and during a redirect.
- imem_valid = (count < DEPTH) && !redirect_valid. It is combinational and never asserted in the cycle a redirect is presented.
- Push:
  - Occurs when imem_valid && imem_ready.
  - Writes {fetch_pc, imem_rdata} at the tail.
  - fetch_pc ← fetch_pc + 4, wrapping modulo 2^XLEN (all-ones−3 → 0).
- Pop:
  - Occurs when out_valid && out_ready; the head advances.
  - out_valid = (count ≠ 0). Outputs come combinationally from the head entry; no bypass.
  - Latency: a word accepted at edge N is presentable at out from cycle N+1.
- Simultaneous push and pop:
  - count unchanged; allowed even when count==DEPTH is not true.
  - When full, imem_valid=0, so a push never coincides with full.
- Redirect (redirect_valid=1 at an edge), highest priority after reset:
  - Queue cleared; count ← 0.
  - Any pop in the same cycle is discarded: decode must treat redirect as a kill of its own stage.
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - misalign_err ← (redirect_pc[1:0] ≠ 0) for exactly one cycle, else 0.
- Back-to-back redirects: the last one wins; each evaluates misalign_err independently.
- Memory stall: while imem_ready=0, imem_addr holds stable and no state changes except pops.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - full/empty are derived from count, not from pointer equality.
- count never exceeds DEPTH and never underflows. Pops with out_valid=0 and pushes when full are impossible by construction; the bench asserts this.

Decomposition:
- Package rv_fetch_pkg:
  - INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0000_0013;
  - typedef fetch_entry_t {pc[XLEN], instr[32]}, with XLEN passed as a parameter to users.
- One sub-module: rv_fetch_queue, a synchronous FIFO with a flush input and count output, parametrised by width and DEPTH.
- PC logic, redirect priority and misalign detection stay in rv_fetch_unit.

Test Plan:
- Reset release, imem_ready=1, out_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8, …
  - out_pc lags imem_addr by one cycle; out_pc_plus4 = out_pc+4; count stays 1.
- out_ready=0, imem_ready=1:
  - count climbs to 4 and imem_valid drops to 0 with imem_addr=0x10 held.
  - Then out_ready=1 drains in order: pc 0x0, 0x4, 0x8, 0xC.
- Full queue, redirect_valid=1, redirect_pc=0x200:
  - Next cycle count=0, out_valid=0, imem_addr=0x200.
  - The next delivered out_pc=0x200.
- redirect_pc=0x206:
  - fetch_pc=0x204; misalign_err=1 for exactly one cycle, then 0.
- redirect_pc=0xFFFF_FFFF_FFFF_FFFC, XLEN=64:
  - Fetches go 0x…FFFC then 0x0 (wrap).
- reset=0 asserted mid-stream with count=3 and redirect_valid=1 in the same cycle:
  - Next cycle count=0, imem_addr=RESET_PC, misalign_err=0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared constants and the fetch-queue entry layout
// for the instruction-fetch front end.
package rv_fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;
  localparam int PC_MAX_W = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // pc is sized for the widest XLEN; narrower users fill the low bits
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_queue.sv
// Synchronous FIFO with flush; full/empty derived from
// the occupancy count rather than pointer equality.
module rv_fetch_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: PC register, imem request,
// fetch queue toward decode and EX-driven redirect.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_valid,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_ready,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       misalign_err
);

  logic [XLEN-1:0] fetch_pc;
  logic            misalign_q;
  logic            q_full;
  logic            q_empty;
  logic            push;
  logic            pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign imem_valid = !q_full && !redirect_valid;
  assign imem_addr  = fetch_pc;
  assign push       = imem_valid && imem_ready;
  // a redirect kills the head, so a same-cycle pop is dropped
  assign pop        = out_valid && out_ready && !redirect_valid;

  always_comb begin
    wr_entry                = '0;
    wr_entry.pc[XLEN-1:0]   = fetch_pc;
    wr_entry.instr          = imem_rdata;
  end

  rv_fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign out_valid    = !q_empty;
  assign out_instr    = out_valid ? head.instr : NOP_INSTR;
  assign out_pc       = head.pc[XLEN-1:0];
  assign out_pc_plus4 = out_pc + XLEN'(PC_STEP);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
      misalign_q <= |redirect_pc[1:0];
    end else begin
      if (push) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      misalign_q <= 1'b0;
    end
  end

endmodule
